// File: rtl/imem_pkg.sv
// imem_pkg: shared types, word width and address helper for the instruction memory arbiter
package imem_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, LOAD} arb_state_e;
  localparam int WORD_W = 32;
  function automatic logic [63:0] word_idx(input logic [63:0] addr);
    return addr >> 2;
  endfunction
endpackage

// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: fetch, loader and RAM signals seen by the arbiter (slave) and its environment (master)
interface imem_arbiter_if #(parameter int ADDR_W = 32, parameter int AW = 7);
  import imem_pkg::*;
  logic fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic fetch_gnt;
  logic fetch_rvalid;
  logic [WORD_W-1:0] fetch_rdata;
  logic fetch_err;
  logic ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [WORD_W-1:0] ld_wdata;
  logic ld_gnt;
  logic mem_en;
  logic mem_we;
  logic [AW-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;
  modport slave (
    input fetch_req, fetch_addr, ld_req, ld_addr, ld_wdata, mem_rdata,
    output fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err, ld_gnt, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output fetch_req, fetch_addr, ld_req, ld_addr, ld_wdata, mem_rdata,
    input fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err, ld_gnt, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_arb_wait_ctr.sv
// imem_arb_wait_ctr: counts loader wins while fetch waits, saturating at MAX_WAIT
module imem_arb_wait_ctr #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic full
);
  localparam int W = $clog2(MAX_WAIT + 1);
  logic [W-1:0] cnt;
  // Clear wins over increment; never counts past MAX_WAIT
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && cnt != W'(MAX_WAIT)) cnt <= cnt + W'(1);
  assign full = cnt == W'(MAX_WAIT);
endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: loader-priority arbiter for the instruction RAM with fetch starvation guard; IMEM_ARB_PERF_EN adds perf counters
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 128,
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  imem_arbiter_if.slave bus,
  output arb_state_e arb_state
`ifdef IMEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic fetch_bad, ld_bad, wait_full, fetch_win, f_gnt, l_gnt, rvalid_q, err_q;
  arb_state_e state_n;
  assign fetch_bad = |bus.fetch_addr[1:0] || word_idx(64'(bus.fetch_addr)) >= 64'(DEPTH);
  assign ld_bad = |bus.ld_addr[1:0] || word_idx(64'(bus.ld_addr)) >= 64'(DEPTH);
  assign fetch_win = bus.fetch_req && (!bus.ld_req || wait_full);
  // Grants and RAM steering follow the requests combinationally, forced to 0 while in reset
  always_comb begin
    f_gnt = rst_n && fetch_win;
    l_gnt = rst_n && bus.ld_req && !fetch_win;
    bus.fetch_gnt = f_gnt;
    bus.ld_gnt = l_gnt;
    bus.mem_we = l_gnt && !ld_bad;
    bus.mem_en = (l_gnt && !ld_bad) || (f_gnt && !fetch_bad);
    bus.mem_addr = f_gnt ? AW'(word_idx(64'(bus.fetch_addr))) : l_gnt ? AW'(word_idx(64'(bus.ld_addr))) : '0;
    bus.mem_wdata = l_gnt ? bus.ld_wdata : '0;
    state_n = f_gnt ? FETCH : l_gnt ? LOAD : IDLE;
  end
  // Status register and the one-cycle read-response pipeline
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      arb_state <= IDLE;
      rvalid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      arb_state <= state_n;
      rvalid_q <= f_gnt;
      err_q <= f_gnt && fetch_bad;
    end
  assign bus.fetch_rvalid = rvalid_q;
  assign bus.fetch_err = err_q;
  assign bus.fetch_rdata = (rvalid_q && !err_q) ? bus.mem_rdata : '0;
  imem_arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk(clk),
    .rst_n(rst_n),
    .inc(l_gnt && bus.fetch_req),
    .clr(f_gnt || !bus.fetch_req),
    .full(wait_full)
  );
`ifdef IMEM_ARB_PERF_EN
  // Saturating counts of fetch grants and of cycles a fetch waits
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (f_gnt && ~&perf_fetch_cnt) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (bus.fetch_req && !f_gnt && ~&perf_stall_cnt) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed and randomized checks of imem_arbiter against a behavioural model
module tb_imem_arbiter;
  import imem_pkg::*;
  localparam int DEPTH = 128;
  localparam int MAX_WAIT = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  arb_state_e arb_state;
  int total = 0;
  int bad = 0;
  int m_wait = 0;
  logic [31:0] ram [DEPTH];
  logic [31:0] ref_mem [DEPTH];
`ifdef IMEM_ARB_PERF_EN
  logic [31:0] pf, ps;
`endif
  imem_arbiter_if #(.ADDR_W(32), .AW(7)) bus ();
  imem_arbiter #(.ADDR_W(32), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .arb_state(arb_state)
`ifdef IMEM_ARB_PERF_EN
    ,
    .perf_fetch_cnt(pf),
    .perf_stall_cnt(ps)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else bus.mem_rdata <= ram[bus.mem_addr];
    end
  function automatic logic [31:0] rand_addr();
    int k;
    k = int'($urandom % 8);
    return k == 0 ? 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3)) :
           k == 1 ? 32'((DEPTH + $urandom_range(0, 1000)) * 4) : 32'($urandom_range(0, 15) * 4);
  endfunction
  function automatic bit addr_ok(input logic [31:0] a);
    return a % 4 == 0 && a / 4 < DEPTH;
  endfunction
  task automatic idle_inputs();
    bus.fetch_req = 1'b0;
    bus.fetch_addr = '0;
    bus.ld_req = 1'b0;
    bus.ld_addr = '0;
    bus.ld_wdata = '0;
  endtask
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_wait = 0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    bus.fetch_req = 1'b1;
    bus.fetch_addr = 32'h4;
    bus.ld_req = 1'b1;
    bus.ld_addr = 32'h8;
    bus.ld_wdata = 32'h1234_5678;
    bus.mem_rdata = 32'h5555_aaaa;
    #1;
    total++;
    if ({bus.fetch_gnt, bus.ld_gnt, bus.mem_en, bus.mem_we, bus.fetch_rvalid, bus.fetch_err} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=000000", {bus.fetch_gnt, bus.ld_gnt, bus.mem_en, bus.mem_we, bus.fetch_rvalid, bus.fetch_err});
    end
    total++;
    if ({bus.mem_addr, bus.mem_wdata, bus.fetch_rdata} !== '0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h/%h exp=0", bus.mem_addr, bus.mem_wdata, bus.fetch_rdata);
    end
    total++;
    if (arb_state !== IDLE) begin
      bad++;
      $display("FAIL reset_state got=%0d exp=%0d", arb_state, IDLE);
    end
`ifdef IMEM_ARB_PERF_EN
    total++;
    if ({pf, ps} !== 64'd0) begin
      bad++;
      $display("FAIL reset_perf got=%0d/%0d exp=0/0", pf, ps);
    end
`endif
    idle_inputs();
  endtask
  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.fetch_req = 1'b1;
      bus.fetch_addr = 32'(i * 4);
      #1;
      total++;
      if ({bus.fetch_gnt, bus.mem_en, bus.mem_we, bus.mem_addr} !== {3'b110, 7'(i)}) begin
        bad++;
        $display("FAIL b2b_gnt%0d got=%b/%0d exp=110/%0d", i, {bus.fetch_gnt, bus.mem_en, bus.mem_we}, bus.mem_addr, i);
      end
      @(posedge clk);
      #1;
      total++;
      if ({bus.fetch_rvalid, bus.fetch_err, bus.fetch_rdata} !== {2'b10, ref_mem[i]}) begin
        bad++;
        $display("FAIL b2b_rd%0d got=%b/%h exp=10/%h", i, {bus.fetch_rvalid, bus.fetch_err}, bus.fetch_rdata, ref_mem[i]);
      end
    end
    total++;
    if (arb_state !== FETCH) begin
      bad++;
      $display("FAIL b2b_state got=%0d exp=%0d", arb_state, FETCH);
    end
    @(negedge clk);
    bus.fetch_req = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({bus.fetch_rvalid, arb_state} !== {1'b0, IDLE}) begin
      bad++;
      $display("FAIL b2b_end got=%b/%0d exp=0/%0d", bus.fetch_rvalid, arb_state, IDLE);
    end
  endtask
  task automatic test_load_then_fetch();
    apply_reset();
    @(negedge clk);
    bus.ld_req = 1'b1;
    bus.ld_addr = 32'h10;
    bus.ld_wdata = 32'hdead_beef;
    #1;
    total++;
    if ({bus.ld_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {3'b111, 7'd4, 32'hdead_beef}) begin
      bad++;
      $display("FAIL ld_write got=%b/%0d/%h exp=111/4/deadbeef", {bus.ld_gnt, bus.mem_en, bus.mem_we}, bus.mem_addr, bus.mem_wdata);
    end
    ref_mem[4] = 32'hdead_beef;
    @(posedge clk);
    #1;
    total++;
    if (arb_state !== LOAD) begin
      bad++;
      $display("FAIL ld_state got=%0d exp=%0d", arb_state, LOAD);
    end
    @(negedge clk);
    bus.ld_req = 1'b0;
    bus.fetch_req = 1'b1;
    bus.fetch_addr = 32'h10;
    @(posedge clk);
    #1;
    total++;
    if ({bus.fetch_rvalid, bus.fetch_err, bus.fetch_rdata} !== {2'b10, 32'hdead_beef}) begin
      bad++;
      $display("FAIL raw_read got=%b/%h exp=10/deadbeef", {bus.fetch_rvalid, bus.fetch_err}, bus.fetch_rdata);
    end
    @(negedge clk);
    bus.fetch_req = 1'b0;
  endtask
  task automatic test_starvation();
    apply_reset();
    for (int k = 0; k < 27; k++) begin
      @(negedge clk);
      bus.fetch_req = 1'b1;
      bus.fetch_addr = 32'h20;
      bus.ld_req = 1'b1;
      bus.ld_addr = 32'h40;
      bus.ld_wdata = 32'(k);
      #1;
      total++;
      if ({bus.fetch_gnt, bus.ld_gnt} !== (k % 9 == 8 ? 2'b10 : 2'b01)) begin
        bad++;
        $display("FAIL starve_cyc%0d got=%b exp=%b", k, {bus.fetch_gnt, bus.ld_gnt}, k % 9 == 8 ? 2'b10 : 2'b01);
      end
    end
    ref_mem[16] = 32'd25;
    @(negedge clk);
    bus.fetch_req = 1'b0;
    #1;
    total++;
    if ({bus.fetch_gnt, bus.ld_gnt} !== 2'b01) begin
      bad++;
      $display("FAIL starve_ld_only got=%b exp=01", {bus.fetch_gnt, bus.ld_gnt});
    end
    ref_mem[16] = 32'd26;
    @(negedge clk);
    idle_inputs();
  endtask
  task automatic test_errors();
    logic [31:0] addrs [3];
    addrs[0] = 32'h2;
    addrs[1] = 32'(DEPTH * 4);
    addrs[2] = 32'h7f;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.fetch_req = 1'b1;
      bus.fetch_addr = addrs[i];
      #1;
      total++;
      if ({bus.fetch_gnt, bus.mem_en} !== 2'b10) begin
        bad++;
        $display("FAIL err_gnt%0d got=%b exp=10", i, {bus.fetch_gnt, bus.mem_en});
      end
      @(posedge clk);
      #1;
      total++;
      if ({bus.fetch_rvalid, bus.fetch_err, bus.fetch_rdata} !== {2'b11, 32'd0}) begin
        bad++;
        $display("FAIL err_rsp%0d got=%b/%h exp=11/0", i, {bus.fetch_rvalid, bus.fetch_err}, bus.fetch_rdata);
      end
    end
    @(negedge clk);
    bus.fetch_req = 1'b0;
    bus.ld_req = 1'b1;
    bus.ld_addr = 32'(DEPTH * 4 + 8);
    bus.ld_wdata = 32'hbad0_bad0;
    #1;
    total++;
    if ({bus.ld_gnt, bus.mem_en, bus.mem_we} !== 3'b100) begin
      bad++;
      $display("FAIL ld_bad_addr got=%b exp=100", {bus.ld_gnt, bus.mem_en, bus.mem_we});
    end
    @(negedge clk);
    idle_inputs();
  endtask
  task automatic test_reset_mid_read();
    apply_reset();
    @(negedge clk);
    bus.fetch_req = 1'b1;
    bus.fetch_addr = 32'h8;
    #1;
    total++;
    if (bus.fetch_gnt !== 1'b1) begin
      bad++;
      $display("FAIL mid_gnt got=%b exp=1", bus.fetch_gnt);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.fetch_gnt, bus.mem_en, bus.mem_addr} !== '0) begin
      bad++;
      $display("FAIL mid_async got=%b/%0d exp=00/0", {bus.fetch_gnt, bus.mem_en}, bus.mem_addr);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.fetch_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL mid_no_rvalid got=%b exp=0", bus.fetch_rvalid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.fetch_rvalid !== 1'b1) begin
      bad++;
      $display("FAIL mid_rvalid got=%b exp=1", bus.fetch_rvalid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.fetch_rvalid, bus.fetch_rdata, arb_state} !== {33'd0, IDLE}) begin
      bad++;
      $display("FAIL mid_async_clr got=%b/%h/%0d exp=0/0/0", bus.fetch_rvalid, bus.fetch_rdata, arb_state);
    end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    m_wait = 0;
  endtask
  task automatic test_random();
    bit f_hold, l_hold, exp_f, exp_l, f_ok, l_ok;
    logic [31:0] exp_data;
    arb_state_e exp_state;
    int exp_pf, exp_ps;
    f_hold = 0;
    l_hold = 0;
    exp_pf = 0;
    exp_ps = 0;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!f_hold) begin
        bus.fetch_req = ($urandom % 4) != 0;
        bus.fetch_addr = rand_addr();
      end
      if (!l_hold) begin
        bus.ld_req = ($urandom % 2) != 0;
        bus.ld_addr = rand_addr();
        bus.ld_wdata = $urandom;
      end
      exp_f = bus.fetch_req && (!bus.ld_req || m_wait == MAX_WAIT);
      exp_l = bus.ld_req && !exp_f;
      f_ok = addr_ok(bus.fetch_addr);
      l_ok = addr_ok(bus.ld_addr);
      #1;
      total++;
      if ({bus.fetch_gnt, bus.ld_gnt, bus.mem_en, bus.mem_we} !== {exp_f, exp_l, (exp_f && f_ok) || (exp_l && l_ok), exp_l && l_ok}) begin
        bad++;
        $display("FAIL rnd_gnt c%0d got=%b exp=%b", c, {bus.fetch_gnt, bus.ld_gnt, bus.mem_en, bus.mem_we},
                 {exp_f, exp_l, (exp_f && f_ok) || (exp_l && l_ok), exp_l && l_ok});
      end
      exp_data = (exp_f && f_ok) ? ref_mem[bus.fetch_addr / 4] : 32'd0;
      if (exp_l && l_ok) ref_mem[bus.ld_addr / 4] = bus.ld_wdata;
      m_wait = (exp_f || !bus.fetch_req) ? 0 : exp_l ? m_wait + 1 : m_wait;
      exp_state = exp_f ? FETCH : exp_l ? LOAD : IDLE;
      exp_pf += int'(exp_f);
      exp_ps += int'(bus.fetch_req && !exp_f);
      f_hold = bus.fetch_req && !exp_f;
      l_hold = bus.ld_req && !exp_l;
      @(posedge clk);
      #1;
      total++;
      if ({bus.fetch_rvalid, bus.fetch_err, bus.fetch_rdata, arb_state} !== {exp_f, exp_f && !f_ok, exp_data, exp_state}) begin
        bad++;
        $display("FAIL rnd_rsp c%0d got=%b/%h/%0d exp=%b/%h/%0d", c, {bus.fetch_rvalid, bus.fetch_err}, bus.fetch_rdata, arb_state,
                 {exp_f, exp_f && !f_ok}, exp_data, exp_state);
      end
    end
`ifdef IMEM_ARB_PERF_EN
    total++;
    if ({pf, ps} !== {32'(exp_pf), 32'(exp_ps)}) begin
      bad++;
      $display("FAIL rnd_perf got=%0d/%0d exp=%0d/%0d", pf, ps, exp_pf, exp_ps);
    end
`endif
    @(negedge clk);
    idle_inputs();
  endtask
`ifdef IMEM_ARB_PERF_EN
  task automatic test_perf();
    apply_reset();
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      bus.fetch_req = 1'b1;
      bus.fetch_addr = 32'h0;
      bus.ld_req = i >= 10;
      bus.ld_addr = 32'h4;
      bus.ld_wdata = ref_mem[1];
    end
    @(negedge clk);
    idle_inputs();
    #1;
    total++;
    if ({pf, ps} !== {32'd10, 32'd3}) begin
      bad++;
      $display("FAIL perf_cnt got=%0d/%0d exp=10/3", pf, ps);
    end
  endtask
`endif
  initial begin
    logic [31:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      ram[i] = v;
      ref_mem[i] = v;
    end
    idle_inputs();
    test_reset();
    test_back_to_back();
    test_load_then_fetch();
    test_starvation();
    test_errors();
    test_reset_mid_read();
    test_random();
`ifdef IMEM_ARB_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
